mac_accum_pe: RTL
=================

# mac_accum_pe

Parametrised, pipelined signed multiply-accumulate processing element for the MAC array. Consumes a stream of operand pairs (a, b) framed by first/last markers, accumulates their products in an ACC_W-bit register with optional saturation, and emits one dot-product result per frame. It is the sequential successor to the team's fixed 8-bit adder. It adds generic width, a valid/ready handshake on both sides, overflow detection and backpressure.

## Interface
Parameters:
- DATA_W, 8, signed operand width.
- ACC_W, 24, signed accumulator/result width; must be ≥ 2*DATA_W.
- SATURATE, 1, 1 = clamp on overflow, 0 = wrap modulo 2^ACC_W.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  PE can accept a beat.
- in_a  in  DATA_W  signed operand A.
- in_b  in  DATA_W  signed operand B.
- in_first  in  1  beat starts a frame; the accumulator is replaced by this beat's product.
- in_last  in  1  beat ends a frame; the result is emitted.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  ACC_W  signed result.
- out_ovf  out  1  overflow occurred anywhere in this frame.

## Operation
- Beat accepted when in_valid && in_ready.
- Three register stages:
  - S1 registers a, b, first, last and a valid bit.
  - S2 registers the signed product (2*DATA_W bits), first, last and a valid bit.
  - S3 updates the accumulator and the output register.
- Product sign-extended to ACC_W before addition.
- Accumulate rule for a valid S2 beat:
  - first=1: acc ← product; ovf_sticky ← 0.
  - first=0: acc ← acc + product.
- Overflow is detected when both addends have the same sign and the sum's sign differs.
  - SATURATE=1: acc clamps to +2^(ACC_W-1)-1 or -2^(ACC_W-1).
  - SATURATE=0: acc keeps the wrapped sum.
  - In both modes ovf_sticky is set.
- last=1 at S3: out_data ← new acc value; out_ovf ← new sticky value; out_valid ← 1.
- Beat with first=1 and last=1: the result equals the product alone.
- Beat with first=0 and no prior frame: accumulates onto the current acc value. This is not an error.
- Stall: the global enable is `stall = out_valid && !out_ready`.
  - While stalled, S1, S2, S3 and the output register hold.
  - in_ready = !stall.
- Output handshake: out_valid clears on out_valid && out_ready, unless a last beat reaches S3 in that same cycle. In that case the output register reloads and out_valid stays 1.
- out_data and out_ovf are stable while out_valid && !out_ready.
- Reset (async, any time, including mid-frame): all valid bits 0, acc 0, sticky 0, out_valid 0, out_data 0, out_ovf 0. in_ready is 1 after reset. Partial frames are discarded.

## Timing
- Latency: a last beat accepted at edge E gives out_valid=1 and the final out_data after edge E+2.
- Throughput: one beat per cycle when out_ready is held high; back-to-back frames have no bubble.
- in_ready is combinational from out_valid/out_ready. No other combinational input-to-output path exists.
- Reset values: in_ready=1, out_valid=0, out_data=0, out_ovf=0.

## Structure
- Shared package mac_pkg holds:
  - default DATA_W/ACC_W constants;
  - the functions sat_max(ACC_W) and sat_min(ACC_W).
- Sub-module sat_add: parametrised signed adder (width W, SATURATE), outputs sum and ovf. It is purely combinational and instantiated once in S3.
- Multiplier is inferred (`$signed` multiply) in S2.

## Test plan
All scenarios use DATA_W=8, ACC_W=20, SATURATE=1 unless stated.
1. Reset, then idle -> in_ready=1, out_valid=0, out_data=0, out_ovf=0.
2. Single beat a=-1, b=-1, first=last=1 at edge E -> out_valid after E+2, out_data=1, out_ovf=0.
3. Frame a={1,2,3,4}, b={5,6,7,8} back-to-back, then frame a={-2}, b={3} first=last -> results 70 then -6 on consecutive cycles, out_ovf=0 for both.
4. ACC_W=16, two beats a=b=-128 (16384 each):
   - SATURATE=1 -> out_data=32767, out_ovf=1.
   - SATURATE=0 -> out_data=-32768 (0x8000), out_ovf=1.
   - A following frame {1×1} -> out_data=1, out_ovf=0.
5. out_ready=0 while two single-beat frames (3×3, 4×4) are sent -> out_data=9 held; in_ready=0 while stalled; no beat lost. Raising out_ready -> 9 then 16, in order.
6. rst_n pulsed low mid-frame after beats {10×10, 10×10} -> out_valid stays 0. A fresh frame {2×2} -> out_data=4.

Source files
------------

// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared widths and saturation limits for the MAC array
package mac_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ACC_W  = 24;
  localparam int LIM_W      = 64;

  function automatic logic signed [LIM_W-1:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [LIM_W-1:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/sat_add.sv
// rtl/sat_add.sv - signed adder with overflow flag and optional clamp
module sat_add
  import mac_pkg::*;
#(
  parameter int W        = DEF_ACC_W,
  parameter bit SATURATE = 1'b1
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] sum,
  output logic                ovf
);

  localparam logic signed [W-1:0] MAX_V = W'(sat_max(W));
  localparam logic signed [W-1:0] MIN_V = W'(sat_min(W));

  logic signed [W-1:0] raw;

  assign raw = a + b;
  // Only like-signed addends can overflow; the clamp direction follows their sign.
  assign ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);

  always_comb begin
    sum = raw;
    if (SATURATE && ovf) begin
      sum = a[W-1] ? MIN_V : MAX_V;
    end
  end

endmodule

// File: rtl/mac_accum_pe.sv
// rtl/mac_accum_pe.sv - pipelined signed multiply-accumulate PE, one result per frame
module mac_accum_pe
  import mac_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ACC_W    = DEF_ACC_W,
  parameter bit SATURATE = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_a,
  input  logic signed [DATA_W-1:0] in_b,
  input  logic                     in_first,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_data,
  output logic                     out_ovf
);

  localparam int PROD_W = 2 * DATA_W;

  logic en;

  logic                     s1_valid, s1_first, s1_last;
  logic signed [DATA_W-1:0] s1_a, s1_b;

  logic                     s2_valid, s2_first, s2_last;
  logic signed [PROD_W-1:0] s2_prod;

  logic signed [ACC_W-1:0]  acc;
  logic                     sticky;
  logic signed [ACC_W-1:0]  prod_ext, add_a, acc_nxt;
  logic                     add_ovf, sticky_nxt;

  // A held result freezes the whole pipe so nothing behind it is lost.
  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_first <= in_first;
      s1_last  <= in_last;
      s1_a     <= in_a;
      s1_b     <= in_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
      s2_prod  <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_first <= s1_first;
      s2_last  <= s1_last;
      s2_prod  <= PROD_W'(s1_a) * PROD_W'(s1_b);
    end
  end

  // A frame start adds the product to zero, which can never overflow.
  assign prod_ext   = ACC_W'(s2_prod);
  assign add_a      = s2_first ? '0 : acc;
  assign sticky_nxt = (s2_first ? 1'b0 : sticky) | add_ovf;

  sat_add #(
    .W        (ACC_W),
    .SATURATE (SATURATE)
  ) u_sat_add (
    .a   (add_a),
    .b   (prod_ext),
    .sum (acc_nxt),
    .ovf (add_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      sticky <= 1'b0;
    end else if (en && s2_valid) begin
      acc    <= acc_nxt;
      sticky <= sticky_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else if (en) begin
      out_valid <= s2_valid && s2_last;
      if (s2_valid && s2_last) begin
        out_data <= acc_nxt;
        out_ovf  <= sticky_nxt;
      end
    end
  end

endmodule
